// File: rtl/z3_master_cycle.sv
// Zorro III bus initiator: runs one non-burst master cycle per request.
// Ports: CLK_50M/IORST_n, BMASTER grant, req_* request, status/rdata, bus pins.
module z3_master_cycle #(
  parameter int ADDR_SETUP     = 2,
  parameter int ADDR_HOLD      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK_50M,
  input  logic        IORST_n,
  input  logic        BMASTER,
  input  logic        req,
  input  logic        req_read,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err_berr,
  output logic        err_timeout,
  output logic [31:0] rdata,
  output logic [31:0] A_out,
  output logic        A_oe,
  output logic [31:0] D_out,
  output logic        D_oe,
  input  logic [31:0] D_in,
  output logic        READ_out,
  output logic        FCS_n_out,
  output logic [3:0]  DS_n_out,
  output logic        DOE,
  input  logic        DTACK_n,
  input  logic        BERR_n
);

  localparam int PMAX =
    (ADDR_SETUP > ADDR_HOLD) ? ADDR_SETUP : ADDR_HOLD;
  localparam int CMAX =
    (TIMEOUT_CYCLES > PMAX) ? TIMEOUT_CYCLES : PMAX;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SETUP_LAST =
    CW'(ADDR_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(ADDR_HOLD - 1);
  localparam logic [CW-1:0] TMO_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASETUP,
    S_STROBE,
    S_DATA,
    S_WAIT,
    S_TERM,
    S_RECOVER
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        dtack_s1_q, dtack_s2_q;
  logic        berr_s1_q, berr_s2_q;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        read_q;
  logic        err_berr_q;
  logic        err_tmo_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic [3:0]  lane_mask;
  logic [2:0]  n_bytes;
  logic [2:0]  lo;
  logic [2:0]  hi;

  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      dtack_s1_q <= 1'b1;
      dtack_s2_q <= 1'b1;
      berr_s1_q  <= 1'b1;
      berr_s2_q  <= 1'b1;
    end else begin
      dtack_s1_q <= DTACK_n;
      dtack_s2_q <= dtack_s1_q;
      berr_s1_q  <= BERR_n;
      berr_s2_q  <= berr_s1_q;
    end
  end

  assign accept = (state_q == S_IDLE) && req && BMASTER;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ASETUP;
          cnt_d   = '0;
        end
      end
      S_ASETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (!berr_s2_q || !dtack_s2_q ||
            cnt_q == TMO_LAST) begin
          state_d = S_TERM;
        end
      end
      S_TERM: begin
        state_d = S_RECOVER;
      end
      S_RECOVER: begin
        if (dtack_s2_q && berr_s2_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // BERR outranks DTACK, and a BERR'd read leaves rdata alone.
  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      read_q     <= 1'b1;
      err_berr_q <= 1'b0;
      err_tmo_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        size_q     <= req_size;
        read_q     <= req_read;
        err_berr_q <= 1'b0;
        err_tmo_q  <= 1'b0;
      end
      if (state_q == S_WAIT) begin
        if (!berr_s2_q) begin
          err_berr_q <= 1'b1;
        end else if (!dtack_s2_q) begin
          if (read_q) begin
            rdata_q <= D_in;
          end
        end else if (cnt_q == TMO_LAST) begin
          err_tmo_q <= 1'b1;
        end
      end
    end
  end

  // Lanes A[1:0]..A[1:0]+n-1, clipped at lane 3.
  always_comb begin
    n_bytes = (size_q == 2'd0) ? 3'd4 : {1'b0, size_q};
    lo      = {1'b0, addr_q[1:0]};
    hi      = lo + n_bytes - 3'd1;
    lane_mask = 4'hF;
    for (int o = 0; o < 4; o++) begin
      if (3'(o) >= lo && 3'(o) <= hi) begin
        lane_mask[2'(3 - o)] = 1'b0;
      end
    end
  end

  logic addr_ph;
  logic data_ph;
  logic cyc_ph;

  assign addr_ph = (state_q == S_ASETUP) ||
                   (state_q == S_STROBE);
  assign data_ph = (state_q == S_DATA) ||
                   (state_q == S_WAIT);
  assign cyc_ph  = addr_ph || data_ph;

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_TERM);
  assign err_berr    = err_berr_q;
  assign err_timeout = err_tmo_q;
  assign rdata       = rdata_q;

  assign A_out     = addr_q;
  assign A_oe      = addr_ph;
  assign D_out     = wdata_q;
  assign D_oe      = data_ph && !read_q;
  assign READ_out  = cyc_ph ? read_q : 1'b1;
  assign FCS_n_out = !((state_q == S_STROBE) || data_ph);
  assign DS_n_out  = data_ph ? lane_mask : 4'hF;
  assign DOE       = data_ph;

endmodule

// File: doc/z3_master_cycle.md
Name: z3_master_cycle

Overview:
- Zorro III bus initiator. Runs single, non-burst master cycles on behalf of a local requester, such as the SCSI DMA path or a future on-board test engine.
- It drives address, FCS_n, DS_n, READ and DOE, then waits for the responding slave's DTACK_n or BERR_n. It returns read data and a status to the requester.
- It sits behind the bus arbiter. It only starts a cycle while BMASTER is asserted.

Parameters:
- ADDR_SETUP, 2: CLK_50M cycles that the address and READ are valid before FCS_n falls.
- ADDR_HOLD, 2: cycles after FCS_n falls before the address is released and the data phase begins.
- TIMEOUT_CYCLES, 1024: cycles waiting for DTACK_n/BERR_n before the cycle is abandoned.

Ports:
- CLK_50M  in  1  clock
- IORST_n  in  1  reset, asynchronous, active-low
- BMASTER  in  1  bus grant held by the arbiter
- req  in  1  start request, level, sampled in IDLE
- req_read  in  1  1 = read, 0 = write
- req_addr  in  32  byte address
- req_size  in  2  0 = long, 1 = byte, 2 = word, 3 = 3-byte
- req_wdata  in  32  write data, big-endian (D31:24 = offset 0)
- busy  out  1  cycle in progress
- done  out  1  one-cycle completion pulse
- err_berr  out  1  status of the last cycle, valid while done
- err_timeout  out  1  status of the last cycle, valid while done
- rdata  out  32  read data, valid from done until the next done
- A_out  out  32  address to bus
- A_oe  out  1  address drive enable
- D_out  out  32  write data to bus
- D_oe  out  1  data drive enable
- D_in  in  32  data from bus
- READ_out  out  1  bus READ
- FCS_n_out  out  1  bus FCS_n
- DS_n_out  out  4  byte strobes
- DOE  out  1  data output enable
- DTACK_n  in  1  slave ack, asynchronous
- BERR_n  in  1  bus error, asynchronous

Behaviour:
- **Reset values:** busy = 0, done = 0, err_* = 0, rdata = 0, A_oe = 0, D_oe = 0, DOE = 0, READ_out = 1, FCS_n_out = 1, DS_n_out = 4'hF, A_out = 0, D_out = 0. Asserting IORST_n at any point, including mid-cycle, returns the block to IDLE and releases the bus immediately (asynchronously).
- **Synchronisers:** DTACK_n and BERR_n each pass through 2-flop synchronisers. The state machine reads only the synchronised versions.
- **Byte lanes:**
  - n = 4 for size 0, otherwise n = size.
  - Lanes enabled are offsets o = A[1:0] through min(A[1:0] + n - 1, 3).
  - Offset o maps to DS_n_out[3-o], active-low.
  - Example: byte at A[1:0] = 2 gives DS_n = 4'b1101. Word at 3 is truncated to DS_n = 4'b1110.
- **IDLE:** If req && BMASTER, latch the request, set busy = 1 and go to ASETUP. If req is high without BMASTER, the request is ignored and stays pending.
- **ASETUP:** A_oe = 1, A_out = latched address, READ_out = req_read. Hold for ADDR_SETUP cycles, then go to STROBE.
- **STROBE:** FCS_n_out = 0. Hold for ADDR_HOLD cycles, then go to DATA.
- **DATA:**
  - A_oe = 0; FCS_n_out stays low.
  - DS_n_out = lane mask, DOE = 1.
  - Write: D_oe = 1, D_out = req_wdata.
  - Timeout counter clears. Go to WAIT.
- **WAIT:** The counter increments each cycle. The first cycle in which any of the following holds moves to TERM:
  - synced BERR_n low: err_berr = 1. BERR takes priority when simultaneous with DTACK, and rdata is not updated.
  - synced DTACK_n low: on a read, rdata <= D_in in the same edge.
  - counter == TIMEOUT_CYCLES - 1: err_timeout = 1.
- **TERM:** DS_n_out = 4'hF, DOE = 0, D_oe = 0, FCS_n_out = 1, READ_out = 1. Pulse done for one cycle and go to RECOVER.
- **RECOVER:** Wait until synced DTACK_n and BERR_n are both high (slave has released), then clear busy and return to IDLE. A new req is accepted no sooner than the cycle after busy falls.
- err_* are cleared when the next request is latched.
- **Latency:** DTACK_n is seen synchronised 2 cycles after assertion. The minimum cycle from req to done is ADDR_SETUP + ADDR_HOLD + 1 + 2 + 1 cycles.
- **BMASTER after start:** BMASTER is not re-sampled once a cycle has started. The arbiter holds the grant while FCS_n is asserted.

Test Plan:
- Read long at 0x40000010, D_in = 0xDEADBEEF, DTACK after 5 cycles -> FCS_n low 2 cycles after A_oe, DS_n = 0, rdata = 0xDEADBEEF, done for 1 cycle, err_* = 0.
- Write byte at offset 2 with wdata 0x00005A00 -> DS_n = 4'b1101, D_oe = 1, READ_out = 0, DOE = 1 until done.
- No DTACK, TIMEOUT_CYCLES = 16 -> err_timeout = 1 exactly 16 cycles after WAIT entry, bus released, FCS_n = 1.
- DTACK and BERR asserted on the same edge during a read -> err_berr = 1, rdata unchanged.
- req held with BMASTER = 0 for 10 cycles, then BMASTER = 1 -> no bus activity until the grant, then a normal cycle.
- IORST_n pulsed low during WAIT -> all outputs return to reset values asynchronously; after release the block is in IDLE and accepts a new req.
